mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter
//   Two-port memory arbiter: port A single-word access, port B 2-word burst,
//   A-priority with a starvation limit for B. Registered Moore mem_* outputs.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
    parameter int WORD_SIZE  = 16,
    parameter int SIZE       = 11,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_req,
    input  logic                   a_we,
    input  logic [SIZE-1:0]        a_addr,
    input  logic [WORD_SIZE-1:0]   a_wd,
    output logic [WORD_SIZE-1:0]   a_rdata,
    output logic                   a_ack,
    input  logic                   b_req,
    input  logic                   b_we,
    input  logic [SIZE-1:0]        b_addr,
    input  logic [2*WORD_SIZE-1:0] b_wd,
    output logic [2*WORD_SIZE-1:0] b_rdata,
    output logic                   b_ack,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [SIZE-1:0]        mem_addr,
    output logic [WORD_SIZE-1:0]   mem_wd,
    input  logic [WORD_SIZE-1:0]   mem_rd
);

    localparam int            CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        A_ACC = 2'd1,
        B_W0  = 2'd2,
        B_W1  = 2'd3
    } state_t;

    state_t                   state, state_nxt;
    logic                     lat_we, lat_we_nxt;
    logic [SIZE-1:0]          lat_addr, lat_addr_nxt;
    logic [WORD_SIZE-1:0]     lat_hi, lat_hi_nxt;
    logic [CW-1:0]            starve_cnt, starve_nxt;
    logic                     mem_read_nxt, mem_write_nxt;
    logic [SIZE-1:0]          mem_addr_nxt;
    logic [WORD_SIZE-1:0]     mem_wd_nxt;
    logic [WORD_SIZE-1:0]     a_rdata_nxt;
    logic [2*WORD_SIZE-1:0]   b_rdata_nxt;
    logic                     a_ack_nxt, b_ack_nxt;
    logic                     pick_b, grant_a, grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_hi     <= '0;
            starve_cnt <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
        end else begin
            state      <= state_nxt;
            lat_we     <= lat_we_nxt;
            lat_addr   <= lat_addr_nxt;
            lat_hi     <= lat_hi_nxt;
            starve_cnt <= starve_nxt;
            mem_read   <= mem_read_nxt;
            mem_write  <= mem_write_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wd     <= mem_wd_nxt;
            a_rdata    <= a_rdata_nxt;
            b_rdata    <= b_rdata_nxt;
            a_ack      <= a_ack_nxt;
            b_ack      <= b_ack_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        lat_we_nxt    = lat_we;
        lat_addr_nxt  = lat_addr;
        lat_hi_nxt    = lat_hi;
        starve_nxt    = starve_cnt;
        mem_read_nxt  = mem_read;
        mem_write_nxt = mem_write;
        mem_addr_nxt  = mem_addr;
        mem_wd_nxt    = mem_wd;
        a_rdata_nxt   = a_rdata;
        b_rdata_nxt   = b_rdata;
        a_ack_nxt     = 1'b0;
        b_ack_nxt     = 1'b0;

        // Arbitrate on the raw requests, then withhold the grant if the winner
        // is the requester just acked, so a stale request never regrants.
        pick_b  = b_req && (!a_req || (starve_cnt == STARVE_LIM));
        grant_a = (state == IDLE) && a_req && !pick_b && !a_ack;
        grant_b = (state == IDLE) && pick_b && !b_ack;

        case (state)
            IDLE: begin
                mem_read_nxt  = 1'b0;
                mem_write_nxt = 1'b0;
                if (grant_a) begin
                    state_nxt     = A_ACC;
                    lat_we_nxt    = a_we;
                    lat_addr_nxt  = a_addr;
                    mem_addr_nxt  = a_addr;
                    mem_wd_nxt    = a_wd;
                    mem_read_nxt  = !a_we;
                    mem_write_nxt = a_we;
                    if (b_req && (starve_cnt != STARVE_LIM)) begin
                        starve_nxt = starve_cnt + CW'(1);
                    end
                end else if (grant_b) begin
                    state_nxt     = B_W0;
                    lat_we_nxt    = b_we;
                    lat_addr_nxt  = b_addr;
                    lat_hi_nxt    = b_wd[2*WORD_SIZE-1:WORD_SIZE];
                    mem_addr_nxt  = b_addr;
                    mem_wd_nxt    = b_wd[WORD_SIZE-1:0];
                    mem_read_nxt  = !b_we;
                    mem_write_nxt = b_we;
                    starve_nxt    = '0;
                end else if (!b_req) begin
                    starve_nxt = '0;
                end
            end
            A_ACC: begin
                if (!lat_we) begin
                    a_rdata_nxt = mem_rd;
                end
                a_ack_nxt     = 1'b1;
                mem_read_nxt  = 1'b0;
                mem_write_nxt = 1'b0;
                state_nxt     = IDLE;
            end
            B_W0: begin
                if (!lat_we) begin
                    b_rdata_nxt[WORD_SIZE-1:0] = mem_rd;
                end
                mem_addr_nxt = lat_addr + SIZE'(1);
                mem_wd_nxt   = lat_hi;
                state_nxt    = B_W1;
            end
            default: begin
                if (!lat_we) begin
                    b_rdata_nxt[2*WORD_SIZE-1:WORD_SIZE] = mem_rd;
                end
                b_ack_nxt     = 1'b1;
                mem_read_nxt  = 1'b0;
                mem_write_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a falling-edge memory model and an
//   ack scoreboard.
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

    typedef struct packed {
        logic        port_b;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [10:0] a_addr = '0;
    logic [15:0] a_wd = '0;
    logic [15:0] a_rdata;
    logic        a_ack;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [10:0] b_addr = '0;
    logic [31:0] b_wd = '0;
    logic [31:0] b_rdata;
    logic        b_ack;
    logic        mem_read, mem_write;
    logic [10:0] mem_addr;
    logic [15:0] mem_wd;
    logic [15:0] mem_rd = '0;

    logic [15:0] mem [0:2047];
    exp_t        sb [$];
    logic [27:0] slog [$];
    int          errors = 0;
    int          checks = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic pb, input logic c, input logic [31:0] d);
        exp_t e;
        e.port_b = pb;
        e.chk    = c;
        e.data   = d;
        return e;
    endfunction

    // Memory acts on the falling edge; the same edge logs strobes and scores acks.
    always @(negedge clk) begin : mon
        exp_t e;
        chk("strobe_excl", 64'(mem_read & mem_write), 64'd0);
        if (mem_read || mem_write) slog.push_back({mem_write, mem_addr, mem_wd});
        if (a_ack || b_ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL ack_unexpected: observed a_ack=%0b b_ack=%0b expected none", a_ack, b_ack);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 64'(b_ack), 64'(e.port_b));
                if (e.chk) chk("rdata", b_ack ? 64'(b_rdata) : 64'(a_rdata), 64'(e.data));
            end
        end
        if (mem_write) mem[mem_addr] = mem_wd;
        if (mem_read)  mem_rd <= mem[mem_addr];
    end

    task automatic a_txn(input logic we, input logic [10:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input bit hold, input bit chg,
                         input logic [10:0] addr2);
        int n;
        n = 0;
        slog.delete();
        sb.push_back(mk(1'b0, !we, {16'h0, exp_rd}));
        a_we = we; a_addr = addr; a_wd = wd; a_req = 1'b1;
        do begin
            @(posedge clk); #1; n++;
            if (chg && n == 1) a_addr = addr2;
        end while (!a_ack && n < 8);
        chk("a_latency", 64'(n), 64'd2);
        if (hold) begin @(posedge clk); #1; end
        a_req = 1'b0;
        @(posedge clk); #1;
        chk("a_ack_pulse", 64'(a_ack), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("a_strobes", 64'(slog.size()), 64'd1);
        if (slog.size() > 0) chk("a_mem_cmd", 64'(slog[0][27:16]), 64'({we, addr}));
    endtask

    task automatic b_txn(input logic we, input logic [10:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
        int n;
        logic [10:0] hi_addr;
        n = 0;
        hi_addr = addr + 11'd1;
        slog.delete();
        sb.push_back(mk(1'b1, !we, exp_rd));
        b_we = we; b_addr = addr; b_wd = wd; b_req = 1'b1;
        do begin
            @(posedge clk); #1; n++;
        end while (!b_ack && n < 8);
        chk("b_latency", 64'(n), 64'd3);
        b_req = 1'b0;
        @(posedge clk); #1;
        chk("b_ack_pulse", 64'(b_ack), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("b_strobes", 64'(slog.size()), 64'd2);
        if (slog.size() == 2) begin
            chk("b_cmd_lo", 64'(slog[0][27:16]), 64'({we, addr}));
            chk("b_cmd_hi", 64'(slog[1][27:16]), 64'({we, hi_addr}));
            if (we) begin
                chk("b_wd_lo", 64'(slog[0][15:0]), 64'(wd[15:0]));
                chk("b_wd_hi", 64'(slog[1][15:0]), 64'(wd[31:16]));
            end
        end
    endtask

    initial begin
        int n;
        int acks;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ack", 64'(a_ack), 64'd0);
        chk("rst_b_ack", 64'(b_ack), 64'd0);
        chk("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wd", 64'(mem_wd), 64'd0);
        chk("rst_rdata", 64'({a_rdata, b_rdata}), 64'd0);
        rst = 1'b0;

        a_txn(1'b1, 11'h005, 16'h1234, 16'h0, 1'b0, 1'b0, 11'h0);
        if (slog.size() > 0) chk("a_write_wd", 64'(slog[0][15:0]), 64'h1234);
        a_txn(1'b0, 11'h005, 16'h0, 16'h1234, 1'b0, 1'b0, 11'h0);

        b_txn(1'b1, 11'h7FF, 32'hBEEF_CAFE, 32'h0);
        b_txn(1'b0, 11'h7FF, 32'h0, 32'hBEEF_CAFE);

        // Stale request held through the ack cycle.
        a_txn(1'b0, 11'h005, 16'h0, 16'h1234, 1'b1, 1'b0, 11'h0);

        // Address changes after grant.
        a_txn(1'b1, 11'h010, 16'h5A5A, 16'h0, 1'b0, 1'b1, 11'h020);
        a_txn(1'b0, 11'h010, 16'h0, 16'h5A5A, 1'b0, 1'b0, 11'h0);

        // Both held: A four times, then B, repeated.
        slog.delete();
        for (int k = 0; k < 10; k++) sb.push_back(mk((k == 4 || k == 9), 1'b0, 32'h0));
        a_we = 1'b0; a_addr = 11'h100; b_we = 1'b0; b_addr = 11'h200;
        a_req = 1'b1; b_req = 1'b1;
        n = 0; acks = 0;
        while (acks < 10 && n < 200) begin
            @(posedge clk); #1; n++;
            if (a_ack || b_ack) acks++;
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("arb_acks", 64'(acks), 64'd10);
        repeat (3) @(posedge clk);
        #1;
        chk("arb_strobes", 64'(slog.size()), 64'd12);
        chk("arb_sb_empty", 64'(sb.size()), 64'd0);

        // Reset during B_W1, then a fresh burst from the held request.
        b_we = 1'b1; b_addr = 11'h300; b_wd = 32'h1111_2222; b_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("bw1_addr", 64'(mem_addr), 64'h301);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_b_ack", 64'(b_ack), 64'd0);
        chk("mid_rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        chk("mid_rst_addr_wd", 64'({mem_addr, mem_wd}), 64'd0);
        chk("mid_rst_rdata", 64'({a_rdata, b_rdata}), 64'd0);
        sb.push_back(mk(1'b1, 1'b0, 32'h0));
        b_wd = 32'h3333_4444;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("fresh_b_w0", 64'({mem_write, mem_addr, mem_wd}), 64'({1'b1, 11'h300, 16'h4444}));
        n = 1;
        while (!b_ack && n < 8) begin @(posedge clk); #1; n++; end
        chk("fresh_b_latency", 64'(n), 64'd3);
        b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b_txn(1'b0, 11'h300, 32'h0, 32'h3333_4444);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
